// File: rtl/b1_scfifo_ptr_mem.sv
// Storage array, read/write pointers and used-word counter for a single-clock FIFO.
// The companion control FSM supplies wr_ena, rd_ena and full_fsm; this block
// qualifies the user requests with them and derives the status flags.
module b1_scfifo_ptr_mem #(
  parameter int DWIDTH           = 8,
  parameter int AWIDTH           = 8,
  parameter int ALMOST_FULL_VAL  = 2**AWIDTH - 4,
  parameter int ALMOST_EMPTY_VAL = 4
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic              wr_ena,
  input  logic              rd_ena,
  input  logic              full_fsm,
  output logic [DWIDTH-1:0] q_o,
  output logic [AWIDTH-1:0] usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 2**AWIDTH;
  // Thresholds are compared against a count one bit wider than usedw so that
  // the full-depth case (usedw wrapped to 0) is representable.
  localparam logic [AWIDTH:0] AF_THR = (AWIDTH+1)'(ALMOST_FULL_VAL);
  localparam logic [AWIDTH:0] AE_THR = (AWIDTH+1)'(ALMOST_EMPTY_VAL);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] usedw_q,  usedw_d;
  logic [DWIDTH-1:0] q_q,      q_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;

  logic              wr_fire;
  logic              rd_fire;
  logic [AWIDTH:0]   cnt;

  assign wr_fire = wrreq_i & wr_ena;
  assign rd_fire = rdreq_i & rd_ena;

  // Next-state for pointers, count, read data and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    q_d      = q_q;
    ovf_d    = ovf_q | (wrreq_i & ~wr_ena);
    unf_d    = unf_q | (rdreq_i & ~rd_ena);

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + AWIDTH'(1);
      q_d      = mem_q[rd_ptr_q];
    end

    // Simultaneous read and write leave the count unchanged.
    case ({wr_fire, rd_fire})
      2'b10:   usedw_d = usedw_q + AWIDTH'(1);
      2'b01:   usedw_d = usedw_q - AWIDTH'(1);
      default: usedw_d = usedw_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; not reset, writes suppressed while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (srst_n_i && wr_fire) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Stored count: full_fsm resolves the wrapped usedw==0 at full depth.
  always_comb begin
    cnt            = full_fsm ? {1'b1, {AWIDTH{1'b0}}} : {1'b0, usedw_q};
    almost_full_o  = (cnt >= AF_THR);
    almost_empty_o = (cnt <  AE_THR);
  end

  assign q_o         = q_q;
  assign usedw_o     = usedw_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_b1_scfifo_ptr_mem.sv
// Directed and random checks of b1_scfifo_ptr_mem with a small FIFO (depth 8)
// and a bench-side queue standing in for the control FSM.
module tb_b1_scfifo_ptr_mem;

  logic       clk_i = 1'b0;
  logic       srst_n_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       wrreq_i = 1'b0;
  logic       rdreq_i = 1'b0;
  logic       wr_ena = 1'b1;
  logic       rd_ena = 1'b0;
  logic       full_fsm = 1'b0;
  logic [7:0] q_o;
  logic [2:0] usedw_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic       overflow_o;
  logic       underflow_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q   = '0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  b1_scfifo_ptr_mem #(
    .DWIDTH(8), .AWIDTH(3), .ALMOST_FULL_VAL(4), .ALMOST_EMPTY_VAL(4)
  ) dut (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .data_i(data_i),
    .wrreq_i(wrreq_i), .rdreq_i(rdreq_i),
    .wr_ena(wr_ena), .rd_ena(rd_ena), .full_fsm(full_fsm),
    .q_o(q_o), .usedw_o(usedw_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".q"},     32'(q_o),            32'(exp_q));
    chk({tag, ".usedw"}, 32'(usedw_o),        32'(n % 8));
    chk({tag, ".afull"}, 32'(almost_full_o),  32'(n >= 4));
    chk({tag, ".aempt"}, 32'(almost_empty_o), 32'(n < 4));
    chk({tag, ".ovf"},   32'(overflow_o),     32'(exp_ovf));
    chk({tag, ".unf"},   32'(underflow_o),    32'(exp_unf));
  endtask

  // One clock: apply request, advance the model, refresh FSM-side permits, check.
  task automatic step(input string tag, input logic wr, input logic rd,
                      input logic [7:0] d, input logic rst_n);
    logic wf, rf;
    wrreq_i  = wr;
    rdreq_i  = rd;
    data_i   = d;
    srst_n_i = rst_n;
    wf = wr & wr_ena;
    rf = rd & rd_ena;
    @(posedge clk_i);
    #1;
    if (!rst_n) begin
      mq.delete();
      exp_q   = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (wr && !wr_ena) exp_ovf = 1'b1;
      if (rd && !rd_ena) exp_unf = 1'b1;
      if (rf) exp_q = mq.pop_front();
      if (wf) mq.push_back(d);
    end
    full_fsm = (mq.size() == 8);
    wr_ena   = !full_fsm;
    rd_ena   = (mq.size() != 0);
    wrreq_i  = 1'b0;
    rdreq_i  = 1'b0;
    srst_n_i = 1'b1;
    #1;
    check_all(tag);
  endtask

  initial begin
    step("reset0", 1'b0, 1'b0, 8'h00, 1'b0);
    step("reset1", 1'b1, 1'b1, 8'hEE, 1'b0);

    for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 8'(8'h10 + i), 1'b1);
    chk("full_fsm_set", 32'(full_fsm), 32'd1);
    step("ovf_at_full", 1'b1, 1'b0, 8'hAA, 1'b1);

    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b1);
    chk("drain_last", 32'(q_o), 32'h17);
    step("unf_at_empty", 1'b0, 1'b1, 8'h00, 1'b1);
    chk("unf_q_hold", 32'(q_o), 32'h17);

    step("clr", 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step("pre3", 1'b1, 1'b0, 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < 10; i++) step("simul", 1'b1, 1'b1, 8'(8'h30 + i), 1'b1);
    chk("simul_q_end", 32'(q_o), 32'h36);

    step("to5a", 1'b1, 1'b0, 8'h40, 1'b1);
    step("to5b", 1'b1, 1'b0, 8'h41, 1'b1);
    chk("at5", 32'(usedw_o), 32'd5);
    step("mid_reset", 1'b1, 1'b0, 8'h55, 1'b0);
    chk("mid_reset_q", 32'(q_o), 32'h00);

    for (int i = 0; i < 10000; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 499) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
